// File: rtl/wb_regfile_sb_if.sv
// wb_regfile_sb_if -- bus bundle for the write-back stage / register file.
//
// Handshake semantics: there is no valid/ready pair on this bus. A retiring
// instruction is presented on opcode/fields/mem_out every cycle and is taken
// on the rising edge only while rdy_46 is high and clr_46 is low. An issue
// (iss_vld_46) is taken under the same condition. rdy_46 low means the image
// sequencer owns the register file and all writes and issues are discarded.
//
// Signals:
//   clr_46, opcode_46, dest_reg_46, targ_reg_46, mem_out1_46, mem_out2_46,
//   iss_vld_46, iss_reg_46, ra_addr_46, rb_addr_46   master -> slave
//   ra_data_46, rb_data_46, ra_busy_46, rb_busy_46,
//   rdy_46, wb_cnt_46, dbg_state_46                 slave -> master
interface wb_regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int FLD_W  = 6,
  parameter int CNT_W  = 16
);
  logic              clr_46;
  logic [5:0]        opcode_46;
  logic [FLD_W-1:0]  dest_reg_46;
  logic [FLD_W-1:0]  targ_reg_46;
  logic [DATA_W-1:0] mem_out1_46;
  logic [DATA_W-1:0] mem_out2_46;
  logic              iss_vld_46;
  logic [FLD_W-1:0]  iss_reg_46;
  logic [FLD_W-1:0]  ra_addr_46;
  logic [FLD_W-1:0]  rb_addr_46;
  logic [DATA_W-1:0] ra_data_46;
  logic [DATA_W-1:0] rb_data_46;
  logic              ra_busy_46;
  logic              rb_busy_46;
  logic              rdy_46;
  logic [CNT_W-1:0]  wb_cnt_46;
  logic              dbg_state_46;

  modport master (
    output clr_46, opcode_46, dest_reg_46, targ_reg_46, mem_out1_46,
           mem_out2_46, iss_vld_46, iss_reg_46, ra_addr_46, rb_addr_46,
    input  ra_data_46, rb_data_46, ra_busy_46, rb_busy_46, rdy_46,
           wb_cnt_46, dbg_state_46
  );

  modport slave (
    input  clr_46, opcode_46, dest_reg_46, targ_reg_46, mem_out1_46,
           mem_out2_46, iss_vld_46, iss_reg_46, ra_addr_46, rb_addr_46,
    output ra_data_46, rb_data_46, ra_busy_46, rb_busy_46, rdy_46,
           wb_cnt_46, dbg_state_46
  );
endinterface

// File: rtl/wb_regfile_sb.sv
// wb_regfile_sb -- write-back stage (stage 5) with register file and busy
// scoreboard.
//
// Ports:
//   clk_46   rising-edge clock
//   rst_46   asynchronous active-low reset
//   bus      wb_regfile_sb_if.slave: retiring instruction, issue, two
//            combinational read ports, rdy_46, wb_cnt_46 and dbg_state_46
//            (current FSM state, 0 = INIT, 1 = READY)
//
// After reset or clr_46 the INIT sequencer writes the power-on image one
// register per cycle; only in READY are write-backs, issues and the commit
// counter live.
//
// Optional feature macro: WB_BYPASS_EN -- forwards a committing write to a
// read port that addresses the same register in the same cycle.
module wb_regfile_sb #(
  parameter int          DATA_W   = 32,
  parameter int          NUM_REGS = 32,
  parameter int          IDX_W    = 5,
  parameter int          FLD_W    = 6,
  parameter int          CNT_W    = 16,
  parameter int          LINK_REG = 31,
  parameter logic [5:0]  CALL_OP  = 6'b001010
) (
  input  logic             clk_46,
  input  logic             rst_46,
  wb_regfile_sb_if.slave   bus
);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [5:0] OP_ADD  = 6'b110001;
  localparam logic [5:0] OP_MUL  = 6'b100111;
  localparam logic [5:0] OP_LDW  = 6'b010111;
  localparam logic [5:0] OP_ADDI = 6'b000100;
  localparam logic [5:0] OP_SUBI = 6'b011111;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [0:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;

  // Power-on image; values beyond DATA_W are truncated, short ones extended.
  function automatic logic [DATA_W-1:0] image_val(input logic [IDX_W-1:0] i);
    logic [31:0] v;
    case (32'(i))
      4:       v = 32'd3;
      29:      v = 32'h51;
      30:      v = 32'd150;
      31:      v = 32'd190;
      default: v = 32'd0;
    endcase
    return DATA_W'(v);
  endfunction

  // Write decode
  logic              wr_req;
  logic [FLD_W-1:0]  wr_fld;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              iss_en;
  logic [IDX_W-1:0]  iss_idx;
  logic              accept;

  always_comb begin
    wr_req  = 1'b0;
    wr_fld  = '0;
    wr_data = bus.mem_out1_46;
    case (bus.opcode_46)
      OP_ADD, OP_MUL: begin
        wr_req = 1'b1;
        wr_fld = bus.targ_reg_46;
      end
      OP_LDW, OP_ADDI, OP_SUBI: begin
        wr_req = 1'b1;
        wr_fld = bus.dest_reg_46;
      end
      CALL_OP: begin
        wr_req  = 1'b1;
        wr_fld  = FLD_W'(LINK_REG);
        wr_data = bus.mem_out2_46;
      end
      default: wr_req = 1'b0;
    endcase
  end

  // A clear in the same cycle wins over any write or issue.
  assign accept  = (state == ST_READY) && !bus.clr_46;
  // Fields with bits at or above NUM_REGS name no register and are ignored.
  assign wr_en   = accept && wr_req && (32'(wr_fld) < NUM_REGS);
  assign wr_idx  = wr_fld[IDX_W-1:0];
  assign iss_en  = accept && bus.iss_vld_46 && (32'(bus.iss_reg_46) < NUM_REGS);
  assign iss_idx = bus.iss_reg_46[IDX_W-1:0];

  always_ff @(posedge clk_46 or negedge rst_46) begin
    if (!rst_46) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy  <= '0;
      state <= ST_INIT;
      idx   <= '0;
      cnt   <= '0;
    end else if (state == ST_INIT) begin
      if (bus.clr_46) begin
        idx <= '0;
      end else begin
        regs[idx] <= image_val(idx);
        busy[idx] <= 1'b0;
        idx       <= idx + IDX_W'(1);
        if (idx == IDX_W'(NUM_REGS - 1)) state <= ST_READY;
      end
    end else begin
      if (bus.clr_46) begin
        state <= ST_INIT;
        idx   <= '0;
      end else begin
        if (wr_en) begin
          regs[wr_idx] <= wr_data;
          busy[wr_idx] <= 1'b0;
          cnt          <= cnt + CNT_W'(1);
        end
        // Placed after the write-back clear so a same-register issue wins.
        if (iss_en) busy[iss_idx] <= 1'b1;
      end
    end
  end

  assign bus.rdy_46       = (state == ST_READY);
  assign bus.wb_cnt_46    = cnt;
  assign bus.dbg_state_46 = state;

  // Read ports
  logic             ra_ok, rb_ok;
  logic [IDX_W-1:0] ra_i, rb_i;

  assign ra_ok = 32'(bus.ra_addr_46) < NUM_REGS;
  assign rb_ok = 32'(bus.rb_addr_46) < NUM_REGS;
  assign ra_i  = bus.ra_addr_46[IDX_W-1:0];
  assign rb_i  = bus.rb_addr_46[IDX_W-1:0];

  always_comb begin
    bus.ra_data_46 = ra_ok ? regs[ra_i] : '0;
    bus.ra_busy_46 = ra_ok && busy[ra_i];
    bus.rb_data_46 = rb_ok ? regs[rb_i] : '0;
    bus.rb_busy_46 = rb_ok && busy[rb_i];
`ifdef WB_BYPASS_EN
    if (ra_ok && wr_en && (ra_i == wr_idx)) begin
      bus.ra_data_46 = wr_data;
      bus.ra_busy_46 = iss_en && (iss_idx == ra_i);
    end
    if (rb_ok && wr_en && (rb_i == wr_idx)) begin
      bus.rb_data_46 = wr_data;
      bus.rb_busy_46 = iss_en && (iss_idx == rb_i);
    end
`endif
  end

endmodule

// File: tb/tb_wb_regfile_sb.sv
`timescale 1ns/1ps
module tb_wb_regfile_sb;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int FW = 6;
  localparam int CW = 16;

  localparam logic [5:0] ADD  = 6'b110001;
  localparam logic [5:0] MUL  = 6'b100111;
  localparam logic [5:0] LDW  = 6'b010111;
  localparam logic [5:0] ADDI = 6'b000100;
  localparam logic [5:0] SUBI = 6'b011111;
  localparam logic [5:0] CALL = 6'b001010;
  localparam logic [5:0] BLT  = 6'b010110;
  localparam logic [5:0] STW  = 6'b010101;
  localparam logic [5:0] NOPE = 6'b111111;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_regfile_sb_if #(.DATA_W(DW), .FLD_W(FW), .CNT_W(CW)) bus ();

  wb_regfile_sb #(
    .DATA_W(DW), .NUM_REGS(NR), .IDX_W(5), .FLD_W(FW), .CNT_W(CW),
    .LINK_REG(31), .CALL_OP(CALL)
  ) dut (
    .clk_46 (clk),
    .rst_46 (rst_n),
    .bus    (bus)
  );

  // reference model: architectural view only
  logic [DW-1:0] m_reg [NR];
  bit            m_busy [NR];
  logic [CW-1:0] m_cnt;
  bit            m_rdy;
  int tests = 0;
  int fails = 0;

  logic [5:0] ops [10] = '{ADD, MUL, LDW, ADDI, SUBI, CALL, BLT, STW, NOPE, 6'b000000};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.clr_46 = 1'b0;
    bus.opcode_46 = NOPE;
    bus.dest_reg_46 = '0;
    bus.targ_reg_46 = '0;
    bus.mem_out1_46 = '0;
    bus.mem_out2_46 = '0;
    bus.iss_vld_46 = 1'b0;
    bus.iss_reg_46 = '0;
  endtask

  task automatic model_zero();
    for (int i = 0; i < NR; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    m_cnt = '0;
    m_rdy = 0;
  endtask

  task automatic model_image();
    for (int i = 0; i < NR; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    m_reg[4] = 3; m_reg[29] = 32'h51; m_reg[30] = 150; m_reg[31] = 190;
    m_rdy = 1;
  endtask

  // Applies the architectural effect of the inputs currently presented.
  task automatic model_edge();
    bit w;
    int r;
    logic [DW-1:0] v;
    w = 0; r = 0; v = bus.mem_out1_46;
    if (m_rdy && !bus.clr_46) begin
      case (bus.opcode_46)
        ADD, MUL:         begin w = 1; r = int'(bus.targ_reg_46); end
        LDW, ADDI, SUBI:  begin w = 1; r = int'(bus.dest_reg_46); end
        CALL:             begin w = 1; r = 31; v = bus.mem_out2_46; end
        default:          w = 0;
      endcase
      if (w && r < NR) begin
        m_reg[r] = v;
        m_busy[r] = 0;
        m_cnt = m_cnt + 1'b1;
      end
      if (bus.iss_vld_46 && int'(bus.iss_reg_46) < NR) m_busy[bus.iss_reg_46] = 1;
    end else if (m_rdy && bus.clr_46) begin
      m_rdy = 0;
    end
  endtask

  // driver: one clock with the presented inputs, then back to idle
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic drive(input logic [5:0] op, input int dest, input int targ,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                       input bit iv, input int ir);
    bus.opcode_46 = op;
    bus.dest_reg_46 = FW'(dest);
    bus.targ_reg_46 = FW'(targ);
    bus.mem_out1_46 = d1;
    bus.mem_out2_46 = d2;
    bus.iss_vld_46 = iv;
    bus.iss_reg_46 = FW'(ir);
  endtask

  task automatic wait_init(input string tag, input int start);
    int n;
    n = start;
    while (bus.rdy_46 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_init_cycles"}, 64'(n), 64'(NR));
    model_image();
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NR; i++) begin
      bus.ra_addr_46 = FW'(i);
      bus.rb_addr_46 = FW'(NR - 1 - i);
      #1;
      chk({tag, "_ra_data"}, 64'(bus.ra_data_46), 64'(m_reg[i]));
      chk({tag, "_ra_busy"}, 64'(bus.ra_busy_46), 64'(m_busy[i]));
      chk({tag, "_rb_data"}, 64'(bus.rb_data_46), 64'(m_reg[NR - 1 - i]));
    end
    chk({tag, "_cnt"}, 64'(bus.wb_cnt_46), 64'(m_cnt));
    chk({tag, "_rdy"}, 64'(bus.rdy_46), 64'(m_rdy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] old;
    logic [CW-1:0] cnt_before;
    int a;

    idle_inputs();
    bus.ra_addr_46 = '0;
    bus.rb_addr_46 = '0;
    model_zero();

    // reset state
    #1;
    chk("rst_rdy", 64'(bus.rdy_46), 64'(0));
    chk("rst_cnt", 64'(bus.wb_cnt_46), 64'(0));
    bus.ra_addr_46 = 6'd4;
    #1;
    chk("rst_reg4", 64'(bus.ra_data_46), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init("por", 0);
    check_all("por");

    // directed decode
    drive(ADD, 0, 5, 32'hDEAD, 32'h0, 0, 0);  step();
    drive(LDW, 7, 0, 32'h1234, 32'h0, 0, 0);  step();
    drive(CALL, 0, 0, 32'h5, 32'h40, 0, 0);   step();
    drive(STW, 3, 3, $urandom, $urandom, 0, 0); step();
    check_all("decode");
    chk("decode_cnt3", 64'(bus.wb_cnt_46), 64'(3));

    // randomized mix, including out-of-range fields and issues
    for (int k = 0; k < 60; k++) begin
      drive(ops[$urandom_range(0, 9)], $urandom_range(0, 39), $urandom_range(0, 39),
            $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 35));
      step();
      a = $urandom_range(0, 33);
      bus.ra_addr_46 = FW'(a);
      #1;
      chk("rand_ra_data", 64'(bus.ra_data_46), 64'(a < NR ? m_reg[a] : '0));
      chk("rand_ra_busy", 64'(bus.ra_busy_46), 64'(a < NR ? m_busy[a] : 0));
    end
    check_all("rand");

    // scoreboard
    drive(ADDI, 9, 0, 32'h11, 32'h0, 0, 0); step();
    drive(NOPE, 0, 0, 32'h0, 32'h0, 1, 9);  step();
    bus.ra_addr_46 = 6'd9;
    #1;
    chk("sb_issue_busy", 64'(bus.ra_busy_46), 64'(1));
    drive(ADDI, 9, 0, 32'h22, 32'h0, 0, 0); step();
    chk("sb_wb_clear", 64'(bus.ra_busy_46), 64'(0));
    drive(ADDI, 9, 0, 32'h33, 32'h0, 1, 9); step();
    chk("sb_issue_wins", 64'(bus.ra_busy_46), 64'(1));
    chk("sb_issue_wins_data", 64'(bus.ra_data_46), 64'(32'h33));
    drive(ADDI, 10, 0, 32'h44, 32'h0, 0, 0); step();
    bus.ra_addr_46 = 6'd10;
    #1;
    chk("sb_nonbusy_wb", 64'(bus.ra_busy_46), 64'(0));

    // out-of-range fields
    cnt_before = bus.wb_cnt_46;
    drive(ADD, 0, 6'b100101, 32'hBAD, 32'h0, 1, 40); step();
    drive(LDW, 33, 0, 32'hBAD, 32'h0, 0, 0); step();
    chk("bounds_cnt", 64'(bus.wb_cnt_46), 64'(cnt_before));
    bus.ra_addr_46 = 6'd40;
    #1;
    chk("bounds_ra40_data", 64'(bus.ra_data_46), 64'(0));
    chk("bounds_ra40_busy", 64'(bus.ra_busy_46), 64'(0));
    check_all("bounds");

    // clear and reload
    drive(ADD, 0, 2, 32'h77, 32'h0, 0, 0); step();
    bus.ra_addr_46 = 6'd2;
    #1;
    chk("clr_pre_reg2", 64'(bus.ra_data_46), 64'(32'h77));
    drive(ADD, 0, 8, 32'hAA, 32'h0, 0, 0);
    bus.clr_46 = 1'b1;
    step();
    chk("clr_rdy_low", 64'(bus.rdy_46), 64'(0));
    cnt_before = m_cnt;
    drive(ADD, 0, 2, 32'h55, 32'h0, 0, 0); step();
    wait_init("clr", 1);
    chk("clr_cnt_kept", 64'(bus.wb_cnt_46), 64'(cnt_before));
    check_all("clr");

    // same-cycle read of a committing write
    drive(ADD, 0, 12, 32'h0, 32'h0, 0, 0); step();
    old = m_reg[12];
    bus.ra_addr_46 = 6'd12;
    drive(ADD, 0, 12, 32'h99, 32'h0, 0, 0);
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_same_cycle", 64'(bus.ra_data_46), 64'(32'h99));
`else
    chk("byp_same_cycle", 64'(bus.ra_data_46), 64'(old));
`endif
    step();
    chk("byp_next_cycle", 64'(bus.ra_data_46), 64'(32'h99));

    // asynchronous reset mid-operation
    drive(ADD, 0, 4, 32'h5A5A, 32'h0, 1, 6);
    #1;
    rst_n = 1'b0;
    #1;
    model_zero();
    idle_inputs();
    bus.ra_addr_46 = 6'd4;
    #1;
    chk("mid_rst_rdy", 64'(bus.rdy_46), 64'(0));
    chk("mid_rst_cnt", 64'(bus.wb_cnt_46), 64'(0));
    chk("mid_rst_reg4", 64'(bus.ra_data_46), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init("mid_rst", 0);
    check_all("mid_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
